// File: rtl/rxd_receiver_if.sv
// Serial receive bundle: the raw RxD line going in, the recovered byte and status coming out.
interface rxd_receiver_if;
    logic       RxD;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_idle;
    logic       framing_err;

    modport master (
        input  RxD,
        output RxD_data, RxD_data_ready, RxD_idle, framing_err
    );

    modport slave (
        output RxD,
        input  RxD_data, RxD_data_ready, RxD_idle, framing_err
    );
endinterface

// File: rtl/rxd_receiver.sv
// 8N1 serial receiver: 16x oversampling, two-flop synchronizer, 3-sample majority vote,
// data/strobe ordered for a downstream stage that latches on the strobe.
module rxd_receiver #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic           clk,
    input  logic           rst,
    rxd_receiver_if.master rx
);
    localparam int DIV = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic [TW-1:0] tickCnt_q;
    logic [3:0]    sampCnt_q;
    logic          vote7_q, vote8_q;
    logic [7:0]    shift_q;
    logic [2:0]    bitIdx_q;
    logic [7:0]    data_q;
    logic          readyPend_q, ready_q;
    logic          ferr_q;

    logic          rxs, tick, startDet, sample9, vote;
    logic [3:0]    sampNext;
    logic          loadData, badStop;

    assign rxs      = sync2_q;
    assign tick     = (tickCnt_q == TICK_LAST);
    assign startDet = tick && (state_q == IDLE) && !rxs;
    // sampNext is the sample number this tick represents
    assign sampNext = startDet ? 4'd0 : sampCnt_q + 4'd1;
    assign sample9  = tick && (sampNext == 4'd9);
    assign vote     = (vote7_q & vote8_q) | (vote7_q & rxs) | (vote8_q & rxs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            tickCnt_q <= '0;
            sampCnt_q <= 4'd0;
            vote7_q   <= 1'b1;
            vote8_q   <= 1'b1;
        end else begin
            sync1_q   <= rx.RxD;
            sync2_q   <= sync1_q;
            tickCnt_q <= tick ? '0 : tickCnt_q + 1'b1;
            if (tick) begin
                sampCnt_q <= sampNext;
                if (sampNext == 4'd7) vote7_q <= rxs;
                if (sampNext == 4'd8) vote8_q <= rxs;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        loadData = 1'b0;
        badStop  = 1'b0;
        case (state_q)
            IDLE:  if (tick && !rxs) state_d = START;
            START: if (sample9) state_d = vote ? IDLE : DATA;
            DATA:  if (sample9 && bitIdx_q == 3'd7) state_d = STOP;
            // leave STOP right at sample 9 so a back-to-back start edge is not missed
            STOP: begin
                if (sample9) begin
                    if (vote) begin
                        loadData = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        badStop  = 1'b1;
                        state_d  = BREAK;
                    end
                end
            end
            BREAK: if (tick && rxs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q  <= 8'h00;
            bitIdx_q <= 3'd0;
        end else if (sample9) begin
            if (state_q == START) begin
                bitIdx_q <= 3'd0;
            end else if (state_q == DATA) begin
                shift_q  <= {vote, shift_q[7:1]};
                bitIdx_q <= bitIdx_q + 3'd1;
            end
        end
    end

    // Data is loaded one clock ahead of the strobe so it is settled when the consumer latches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q      <= 8'h00;
            readyPend_q <= 1'b0;
            ready_q     <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            if (loadData) data_q <= shift_q;
            readyPend_q <= loadData;
            ready_q     <= readyPend_q;
            ferr_q      <= badStop;
        end
    end

    assign rx.RxD_data       = data_q;
    assign rx.RxD_data_ready = ready_q;
    assign rx.RxD_idle       = (state_q == IDLE);
    assign rx.framing_err    = ferr_q;
endmodule

// File: tb/tb_rxd_receiver.sv
// Self-checking bench for rxd_receiver: a byte-queue model of good frames checked on every
// strobe, plus directed literal checks for reset, latency, glitches, framing and baud skew.
module tb_rxd_receiver;
    localparam int BIT_CLKS = 432;
    localparam int TICK_CLKS = 27;

    logic clk = 1'b0;
    logic rst;

    rxd_receiver_if bus();

    rxd_receiver #(
        .CLK_FREQ(50000000),
        .BAUD(115200),
        .OVERSAMPLE(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(bus)
    );

    always #10 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         strobes = 0;
    int         ferrCount = 0;
    longint     cycle = 0;
    longint     lastStrobeCycle = 0;
    logic [7:0] expQ[$];
    logic [7:0] prevData = 8'h00;
    bit         expectReadyNext = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one frame (start, 8 data LSB first, stop); optionally inject a 1-tick inverted
    // spike around sample 8 of frame position spikePos.
    task automatic applyStimulus(input logic [7:0] data, input int bitClks, input bit stopLevel,
                                 input int spikePos);
        logic [9:0] frame;
        frame = {stopLevel, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.RxD = frame[i];
            if (i == spikePos) begin
                repeat (8 * TICK_CLKS) @(negedge clk);
                bus.RxD = ~frame[i];
                repeat (TICK_CLKS) @(negedge clk);
                bus.RxD = frame[i];
                repeat (bitClks - 9 * TICK_CLKS) @(negedge clk);
            end else begin
                repeat (bitClks) @(negedge clk);
            end
        end
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    // Compare process: every strobe must match the oldest expected byte, with data settled a cycle earlier
    always @(negedge clk) begin
        if (rst) begin
            prevData        = bus.RxD_data;
            expectReadyNext = 1'b0;
        end else begin
            if (expectReadyNext)
                checkOutput("strobe follows data change", {31'd0, bus.RxD_data_ready}, 32'd1);
            expectReadyNext = 1'b0;
            if (bus.RxD_data_ready || bus.framing_err)
                checkOutput("ready/ferr exclusive", {31'd0, bus.RxD_data_ready & bus.framing_err}, 32'd0);
            if (bus.RxD_data_ready) begin
                strobes++;
                lastStrobeCycle = cycle;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected strobe: got data 0x%0h, expected no strobe", bus.RxD_data);
                end else begin
                    logic [7:0] e;
                    e = expQ.pop_front();
                    checkOutput("strobe data", {24'd0, bus.RxD_data}, {24'd0, e});
                    checkOutput("data setup before strobe", {24'd0, prevData}, {24'd0, e});
                end
            end else if (bus.RxD_data !== prevData) begin
                expectReadyNext = 1'b1;
            end
            if (bus.framing_err) ferrCount++;
            prevData = bus.RxD_data;
        end
    end

    initial begin
        longint startCycle;
        longint lat;

        // Reset values, then a second reset asserted mid tick count
        rst     = 1'b1;
        bus.RxD = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset RxD_data", {24'd0, bus.RxD_data}, 32'h00);
        checkOutput("reset ready", {31'd0, bus.RxD_data_ready}, 32'd0);
        checkOutput("reset framing_err", {31'd0, bus.framing_err}, 32'd0);
        checkOutput("reset idle", {31'd0, bus.RxD_idle}, 32'd1);
        rst = 1'b0;
        repeat (13) @(negedge clk);
        rst = 1'b1;
        #2;
        checkOutput("mid-count reset idle", {31'd0, bus.RxD_idle}, 32'd1);
        checkOutput("mid-count reset data", {24'd0, bus.RxD_data}, 32'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (5000) @(negedge clk);
        checkOutput("no strobe on idle line", strobes, 32'd0);
        checkOutput("idle after idle line", {31'd0, bus.RxD_idle}, 32'd1);

        // Single byte with strobe latency measured from the start edge
        expQ.push_back(8'hA5);
        startCycle = cycle;
        applyStimulus(8'hA5, BIT_CLKS, 1'b1, -1);
        repeat (2 * BIT_CLKS) @(negedge clk);
        checkOutput("A5 strobe count", strobes, 32'd1);
        checkOutput("A5 data", {24'd0, bus.RxD_data}, 32'hA5);
        lat = lastStrobeCycle - startCycle;
        checkOutput("A5 strobe latency in window", {31'd0, (lat >= 4128 && lat <= 4168)}, 32'd1);
        checkOutput("A5 no framing error", ferrCount, 32'd0);

        // Mid-frame reset: start a frame, reset while it is in flight
        bus.RxD = 1'b0;
        repeat (3 * BIT_CLKS) @(negedge clk);
        rst     = 1'b1;
        bus.RxD = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (12 * BIT_CLKS) @(negedge clk);
        checkOutput("mid-frame reset no strobe", strobes, 32'd1);
        checkOutput("mid-frame reset no error", ferrCount, 32'd0);
        checkOutput("mid-frame reset idle", {31'd0, bus.RxD_idle}, 32'd1);

        // Back-to-back frames with no idle gap
        expQ.push_back(8'h00);
        expQ.push_back(8'hFF);
        expQ.push_back(8'h80);
        applyStimulus(8'h00, BIT_CLKS, 1'b1, -1);
        applyStimulus(8'hFF, BIT_CLKS, 1'b1, -1);
        applyStimulus(8'h80, BIT_CLKS, 1'b1, -1);
        repeat (2 * BIT_CLKS) @(negedge clk);
        checkOutput("back-to-back strobe count", strobes, 32'd4);
        checkOutput("back-to-back last data", {24'd0, bus.RxD_data}, 32'h80);

        // 100-clock low glitch on an idle line
        bus.RxD = 1'b0;
        repeat (100) @(negedge clk);
        bus.RxD = 1'b1;
        repeat (1000) @(negedge clk);
        checkOutput("glitch no strobe", strobes, 32'd4);
        checkOutput("glitch back to idle", {31'd0, bus.RxD_idle}, 32'd1);

        // One-tick spike inside data bit 3 must not flip it
        expQ.push_back(8'h6B);
        applyStimulus(8'h6B, BIT_CLKS, 1'b1, 4);
        repeat (2 * BIT_CLKS) @(negedge clk);
        checkOutput("spike byte data", {24'd0, bus.RxD_data}, 32'h6B);
        checkOutput("spike strobe count", strobes, 32'd5);

        // Framing error then a long break
        applyStimulus(8'h3C, BIT_CLKS, 1'b0, -1);
        repeat (20 * BIT_CLKS) @(negedge clk);
        checkOutput("framing error pulses", ferrCount, 32'd1);
        checkOutput("framing no strobe", strobes, 32'd5);
        checkOutput("data held after framing error", {24'd0, bus.RxD_data}, 32'h6B);
        bus.RxD = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        expQ.push_back(8'h3C);
        applyStimulus(8'h3C, BIT_CLKS, 1'b1, -1);
        repeat (2 * BIT_CLKS) @(negedge clk);
        checkOutput("recovered 3C data", {24'd0, bus.RxD_data}, 32'h3C);

        // Baud skew of about +-3%
        expQ.push_back(8'h55);
        applyStimulus(8'h55, 419, 1'b1, -1);
        repeat (2 * BIT_CLKS) @(negedge clk);
        checkOutput("fast baud 55", {24'd0, bus.RxD_data}, 32'h55);
        expQ.push_back(8'hC3);
        applyStimulus(8'hC3, 445, 1'b1, -1);
        repeat (2 * BIT_CLKS) @(negedge clk);
        checkOutput("slow baud C3", {24'd0, bus.RxD_data}, 32'hC3);

        checkOutput("total strobes", strobes, 32'd8);
        checkOutput("total framing errors", ferrCount, 32'd1);
        checkOutput("expected queue drained", expQ.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rxd_receiver.md
# rxd_receiver

Asynchronous serial (8N1) receiver that recovers bytes from the RxD line. It delivers `RxD_data` plus a single-cycle `RxD_data_ready` strobe to the servo pulse generator directly downstream, which latches the byte on that strobe. Reception uses a 16x oversampled bit clock, a two-flop input synchronizer and majority-vote sampling. Bad frames are flagged and never forwarded.

## Interface
- `CLK_FREQ`, 50000000: clock frequency in Hz.
- `BAUD`, 115200: serial bit rate.
- `OVERSAMPLE`, 16: sample ticks per bit. The RTL supports 16 only; the parameter is documentary.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `RxD`  in  1  raw serial line, idle high, asynchronous to `clk`.
- `RxD_data`  out  8  last good byte received; feeds the servo stage data input.
- `RxD_data_ready`  out  1  one-`clk` pulse per good byte; feeds the servo stage enable.
- `RxD_idle`  out  1  high while the FSM is in IDLE.
- `framing_err`  out  1  one-`clk` pulse when a stop bit samples low.

## Operation
- **Synchronizer:** two flops on `RxD`, both reset to 1. All logic uses the synchronized value `rxs`.
- **Tick generator:**
  - Free-running counter with DIV = round(CLK_FREQ/(BAUD*16)), which is 27 at the defaults.
  - `tick` asserts for one `clk` when the count equals DIV-1, then the count wraps to 0.
  - Counter width is clog2(DIV).
- **Sample counter:** 4 bits, advances on `tick`, wraps 15 to 0. It is cleared to 0 on the tick that detects a start edge.
- **Majority vote:** the bit value is the majority of `rxs` at sample counts 7, 8 and 9. The value is resolved at sample 9.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
  - IDLE: on a tick with `rxs`=0, go to START and clear the sample counter.
  - START: at sample 9, a majority of 0 goes to DATA with bit index 0. A majority of 1 is a glitch; return to IDLE with no output.
  - DATA: at each sample 9, shift the voted bit into the shift register, LSB first, and increment the 3-bit index. After index 7, go to STOP.
  - STOP, majority 1: on the next `clk`, load the shift register into `RxD_data`; on the `clk` after that, pulse `RxD_data_ready`. Return to IDLE immediately after sample 9, not at the end of the bit, so a back-to-back start edge is caught.
  - STOP, majority 0: pulse `framing_err` on the next `clk`. Leave `RxD_data` unchanged and do not pulse `RxD_data_ready`. Go to BREAK.
  - BREAK: wait for `rxs`=1 on a tick, then go to IDLE. A held-low line produces exactly one `framing_err`.
- **Output hold:** `RxD_data` changes only on a good frame and holds until the next one.
- **Data/strobe ordering:** `RxD_data` is stable for at least 1 `clk` before `RxD_data_ready` rises. This is required because the downstream stage latches on the strobe edge.

## Timing
- **Reset values:**
  - `RxD_data`=0x00, `RxD_data_ready`=0, `framing_err`=0, `RxD_idle`=1.
  - State IDLE; tick and sample counters 0; synchronizer flops 1.
- **Mid-frame reset:** `rst` asserted during a frame aborts it with no strobe and no error. After release the FSM waits in IDLE for the next falling edge.
- **Start detection:** resolution is 1 tick (DIV `clk`), plus 2 `clk` of synchronizer latency.
- **Bit period:** 16*DIV `clk`, which is 432 at the defaults.
- **Strobe latency:**
  - Stop-bit sample-9 tick at cycle N: `RxD_data` valid at N+1, `RxD_data_ready` high during N+2 only.
  - Measured from the nominal start-bit falling edge, the strobe arrives about 9.56 bit periods + 4 `clk` later.
- **Back-to-back frames:** maximum rate is one byte per 10 bit periods, with no dropped frames.
- **Exclusivity:** `RxD_data_ready` and `framing_err` are never high in the same cycle.
- **Baud tolerance:** receiver clock mismatch up to ±3% must still decode correctly.

## Test plan
- **Reset:** assert `rst` mid-count, then release. All outputs are at reset values; `RxD` held high for 5000 `clk` gives no strobe.
- **Single byte:** send 0xA5 at 432 `clk`/bit. `RxD_data`=0xA5 one `clk` before a single 1-cycle `RxD_data_ready`; `framing_err` stays 0.
- **Back-to-back:** send 0x00, 0xFF, 0x80 with no idle gap between stop and start bits. Three strobes occur, with data 0x00, 0xFF, 0x80 in order.
- **Glitch rejection:**
  - A 100-`clk` low pulse on an idle line gives no strobe, and the FSM returns to IDLE.
  - A 1-tick spike inside a data bit at sample 8 does not change that bit.
- **Framing error:** send 0x3C with the stop bit driven low, then hold low for 20 bit periods. Exactly one `framing_err` pulse, no strobe, and `RxD_data` keeps its prior value. After release to high, 0x3C sent correctly is received.
- **Baud skew:** send 0x55 and 0xC3 at 419 and 445 `clk`/bit (±3%). Both are received correctly.
